stage_if_queued: RTL and testbench

Instruction-fetch stage with a parametrised prefetch queue, decoupling a variable-latency, pipelined instruction memory from the IF→ID register. It issues in-order fetch requests ahead of decode, buffers up to DEPTH returned words, and tags exceptions and interrupts per instruction. Jumps flush the queue and drop in-flight responses. It replaces the single-latch fetch stage and drives the IF→ID interstage bus.

---
 rtl/stage_if_queued_pkg.sv | 13 +
 rtl/stage_if_queued_if.sv | 23 ++
 rtl/stage_if_queued_if_fifo.sv | 62 ++++++
 rtl/stage_if_queued.sv | 166 ++++++++++++++++
 tb/tb_stage_if_queued.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_queued_pkg.sv
// rtl/stage_if_queued_pkg.sv - shared exception codes, reset address and queue entry field widths
package stage_if_queued_pkg;

    localparam int EXC_CODE_WIDTH = 4;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 4'h0;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_INT  = 4'hF;

    localparam logic [31:0] SYSTEM_STARTUP_ADDR = 32'h0000_0000;

    localparam int IFQ_INSTR_W = 32;
    localparam int IFQ_PC_W    = 32;

endpackage

// File: rtl/stage_if_queued_if.sv
// rtl/stage_if_queued_if.sv - pipelined instruction memory request/response bus
interface stage_if_queued_if
    import stage_if_queued_pkg::*;
#(
    parameter int EXC_W = EXC_CODE_WIDTH
);
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic [EXC_W-1:0] mem_exc_code;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_exc_code
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata, mem_exc_code
    );
endinterface

// File: rtl/stage_if_queued_if_fifo.sv
// rtl/stage_if_queued_if_fifo.sv - generic synchronous FIFO with push/pop/flush and occupancy count
module stage_if_queued_if_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointer and count update; flush wins over push/pop, pointers wrap at the power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/stage_if_queued.sv
// rtl/stage_if_queued.sv - prefetching fetch stage feeding IF->ID; IF_QUEUE_BYPASS_EN enables empty-queue bypass
module stage_if_queued
    import stage_if_queued_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = SYSTEM_STARTUP_ADDR,
    parameter int          EXC_W    = EXC_CODE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 clear,
    input  logic                 has_int_pending,
    input  logic                 jmp_flag,
    input  logic [31:0]          jmp_dest,
    output logic                 if2id_valid,
    output logic [31:0]          if2id_instr,
    output logic [31:0]          if2id_pc,
    output logic [EXC_W-1:0]     if2id_exc_code,
    stage_if_queued_if.master    mem_bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = IFQ_INSTR_W + IFQ_PC_W + EXC_W;
    localparam logic [CW:0]      DEPTH_LIM = (CW+1)'(DEPTH);
    localparam logic [EXC_W-1:0] EXC_NONE  = EXC_W'(EC_NONE);
    localparam logic [EXC_W-1:0] EXC_INT   = EXC_W'(EC_INT);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             halted_q, halted_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic             if2id_valid_q, if2id_valid_d;
    logic [31:0]      if2id_instr_q, if2id_instr_d;
    logic [31:0]      if2id_pc_q, if2id_pc_d;
    logic [EXC_W-1:0] if2id_exc_q, if2id_exc_d;

    logic             req, grant, rsp_keep, rsp_exc, pop_ok, bypass, deliver;
    logic             q_push, q_pop, q_empty;
    logic [CW-1:0]    q_count, a_count;
    logic [EW-1:0]    q_head, rsp_entry, src_entry;
    logic [31:0]      a_head;
    logic             unused_a_count;

    // Requests are throttled so every granted word is guaranteed a queue slot.
    assign req = !rst && !halted_q && !jmp_flag
              && (({1'b0, q_count} + {1'b0, outstanding_q}) < DEPTH_LIM);
    assign grant            = req && mem_bus.mem_gnt;
    assign mem_bus.mem_req  = req;
    assign mem_bus.mem_addr = fetch_pc_q;

    // Responses owed to a pre-jump fetch stream are counted off by drop_cnt, never stored.
    assign rsp_keep  = mem_bus.mem_rvalid && !jmp_flag && (drop_cnt_q == '0);
    assign rsp_exc   = mem_bus.mem_exc_code != EXC_NONE;
    assign rsp_entry = {(rsp_exc ? 32'h0 : mem_bus.mem_rdata), a_head, mem_bus.mem_exc_code};
    assign pop_ok    = !stall && !clear && !jmp_flag;
    assign q_empty   = (q_count == '0);

`ifdef IF_QUEUE_BYPASS_EN
    assign bypass = rsp_keep && pop_ok && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign q_push    = rsp_keep && !bypass;
    assign q_pop     = pop_ok && !q_empty;
    assign deliver   = pop_ok && (!q_empty || bypass);
    assign src_entry = q_empty ? rsp_entry : q_head;

    assign unused_a_count = ^a_count;

    stage_if_queued_if_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_entry_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jmp_flag),
        .push  (q_push),
        .wdata (rsp_entry),
        .pop   (q_pop),
        .rdata (q_head),
        .count (q_count)
    );

    stage_if_queued_if_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jmp_flag),
        .push  (grant),
        .wdata (fetch_pc_q),
        .pop   (rsp_keep),
        .rdata (a_head),
        .count (a_count)
    );

    // Fetch-side bookkeeping and IF->ID next-state selection.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        halted_d      = halted_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(mem_bus.mem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        if2id_valid_d = if2id_valid_q;
        if2id_instr_d = if2id_instr_q;
        if2id_pc_d    = if2id_pc_q;
        if2id_exc_d   = if2id_exc_q;

        if (jmp_flag) begin
            fetch_pc_d = jmp_dest;
            halted_d   = 1'b0;
            drop_cnt_d = outstanding_q - CW'(mem_bus.mem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep && rsp_exc) begin
                halted_d = 1'b1;
            end
            if (mem_bus.mem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end

        if (!stall) begin
            if (deliver) begin
                if2id_valid_d = 1'b1;
                if2id_pc_d    = src_entry[EXC_W +: 32];
                if (has_int_pending && (src_entry[EXC_W-1:0] == EXC_NONE)) begin
                    if2id_instr_d = 32'h0;
                    if2id_exc_d   = EXC_INT;
                end else begin
                    if2id_instr_d = src_entry[EW-1 -: 32];
                    if2id_exc_d   = src_entry[EXC_W-1:0];
                end
            end else if (clear || !jmp_flag) begin
                if2id_valid_d = 1'b0;
                if2id_instr_d = 32'h0;
                if2id_exc_d   = EXC_NONE;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            halted_q      <= 1'b0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            if2id_valid_q <= 1'b0;
            if2id_instr_q <= 32'h0;
            if2id_pc_q    <= 32'h0;
            if2id_exc_q   <= EXC_NONE;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            halted_q      <= halted_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            if2id_valid_q <= if2id_valid_d;
            if2id_instr_q <= if2id_instr_d;
            if2id_pc_q    <= if2id_pc_d;
            if2id_exc_q   <= if2id_exc_d;
        end
    end

    assign if2id_valid    = if2id_valid_q;
    assign if2id_instr    = if2id_instr_q;
    assign if2id_pc       = if2id_pc_q;
    assign if2id_exc_code = if2id_exc_q;
endmodule

// File: tb/tb_stage_if_queued.sv
// tb/tb_stage_if_queued.sv - directed self-checking bench for stage_if_queued
module tb_stage_if_queued;
    import stage_if_queued_pkg::*;

`ifdef IF_QUEUE_BYPASS_EN
    localparam int FIRST = 2;
`else
    localparam int FIRST = 3;
`endif
    localparam logic [3:0] EXC_TLB = 4'h3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        clear = 1'b0;
    logic        has_int_pending = 1'b0;
    logic        jmp_flag = 1'b0;
    logic [31:0] jmp_dest = 32'h0;
    logic        if2id_valid;
    logic [31:0] if2id_instr;
    logic [31:0] if2id_pc;
    logic [3:0]  if2id_exc_code;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_lat  = 1;
    logic        exc_en   = 1'b0;
    logic [31:0] exc_addr = 32'h0;
    int          cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    stage_if_queued_if #(.EXC_W(4)) mem_if ();

    stage_if_queued #(.DEPTH(4), .RESET_PC(32'h0), .EXC_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .clear           (clear),
        .has_int_pending (has_int_pending),
        .jmp_flag        (jmp_flag),
        .jmp_dest        (jmp_dest),
        .if2id_valid     (if2id_valid),
        .if2id_instr     (if2id_instr),
        .if2id_pc        (if2id_pc),
        .if2id_exc_code  (if2id_exc_code),
        .mem_bus         (mem_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    // Memory model: always grants, answers in order mem_lat cycles after the grant edge.
    initial begin : mem_model
        logic        g;
        logic        r;
        logic [31:0] a;
        mem_if.mem_gnt      = 1'b1;
        mem_if.mem_rvalid   = 1'b0;
        mem_if.mem_rdata    = 32'h0;
        mem_if.mem_exc_code = 4'h0;
        forever begin
            @(negedge clk);
            #3;
            g = mem_if.mem_req && mem_if.mem_gnt;
            a = mem_if.mem_addr;
            r = rst;
            @(posedge clk);
            #1;
            cyc++;
            if (r) mq.delete();
            else if (g) mq.push_back('{addr: a, due: cyc + mem_lat});
            if (!r && mq.size() > 0 && mq[0].due == cyc + 1) begin
                mem_if.mem_rvalid   = 1'b1;
                mem_if.mem_rdata    = mem_word(mq[0].addr);
                mem_if.mem_exc_code = (exc_en && mq[0].addr == exc_addr) ? EXC_TLB : 4'h0;
                void'(mq.pop_front());
            end else begin
                mem_if.mem_rvalid   = 1'b0;
                mem_if.mem_rdata    = 32'h0;
                mem_if.mem_exc_code = 4'h0;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; stall = 1'b0; clear = 1'b0; has_int_pending = 1'b0; jmp_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_if.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_if.mem_req);
        end
        n_checks++;
        if (mem_if.mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_if.mem_addr);
        end
        n_checks++;
        if ({if2id_valid, if2id_instr, if2id_pc, if2id_exc_code} !== {1'b0, 32'h0, 32'h0, EC_NONE}) begin
            n_fail++;
            $display("FAIL reset_if2id: got v=%b i=%h pc=%h e=%h expected all zero",
                     if2id_valid, if2id_instr, if2id_pc, if2id_exc_code);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        mem_lat = 1; exc_en = 1'b0;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_checks++;
                if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b1, 32'h0}) begin
                    n_fail++;
                    $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000000",
                             mem_if.mem_req, mem_if.mem_addr);
                end
            end
            n_checks++;
            if (k < FIRST) begin
                if ({if2id_valid, if2id_pc} !== {1'b0, 32'h0}) begin
                    n_fail++;
                    $display("FAIL stream_k%0d: got v=%b pc=%h expected bubble pc=0", k, if2id_valid, if2id_pc);
                end
            end else begin
                pc = 32'((k - FIRST) * 4);
                if ({if2id_valid, if2id_instr, if2id_pc, if2id_exc_code} !== {1'b1, mem_word(pc), pc, EC_NONE}) begin
                    n_fail++;
                    $display("FAIL stream_k%0d: got v=%b i=%h pc=%h e=%h expected pc=%h i=%h",
                             k, if2id_valid, if2id_instr, if2id_pc, if2id_exc_code, pc, mem_word(pc));
                end
            end
        end
    endtask

    task automatic test_stall();
        int          grants = 0;
        logic [31:0] pc;
        mem_lat = 1; exc_en = 1'b0;
        apply_reset();
        stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_if.mem_req && mem_if.mem_gnt) grants++;
        end
        n_checks++;
        if (grants !== 4) begin
            n_fail++; $display("FAIL stall_grants: got %0d expected 4", grants);
        end
        n_checks++;
        if ({mem_if.mem_req, mem_if.mem_addr, if2id_valid} !== {1'b0, 32'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_full: got req=%b addr=%h v=%b expected req=0 addr=00000010 v=0",
                     mem_if.mem_req, mem_if.mem_addr, if2id_valid);
        end
        stall = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            pc = 32'(j * 4);
            n_checks++;
            if ({if2id_valid, if2id_instr, if2id_pc, if2id_exc_code} !== {1'b1, mem_word(pc), pc, EC_NONE}) begin
                n_fail++;
                $display("FAIL stall_drain_%0d: got v=%b i=%h pc=%h e=%h expected pc=%h",
                         j, if2id_valid, if2id_instr, if2id_pc, if2id_exc_code, pc);
            end
        end
    endtask

    task automatic test_jump();
        int          got = 0;
        logic [31:0] pc;
        mem_lat = 3; exc_en = 1'b0;
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 4) jmp_flag = 1'b0;
            if (if2id_valid && got < 2) begin
                pc = 32'h8000_0100 + 32'(got * 4);
                n_checks++;
                if ({if2id_instr, if2id_pc, if2id_exc_code} !== {mem_word(pc), pc, EC_NONE}) begin
                    n_fail++;
                    $display("FAIL jump_deliver_%0d: got i=%h pc=%h e=%h expected pc=%h i=%h",
                             got, if2id_instr, if2id_pc, if2id_exc_code, pc, mem_word(pc));
                end
                got++;
            end
            if (k == 3) begin
                jmp_flag = 1'b1;
                jmp_dest = 32'h8000_0100;
            end
        end
        n_checks++;
        if (got !== 2) begin
            n_fail++; $display("FAIL jump_timeout: got %0d deliveries expected 2", got);
        end
    endtask

    task automatic test_exception();
        logic found = 1'b0;
        int   reqs  = 0;
        mem_lat = 1; exc_en = 1'b1; exc_addr = 32'h10;
        apply_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (if2id_valid && if2id_pc == 32'h10) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL exc_timeout: got no delivery expected pc=00000010");
        end
        n_checks++;
        if ({if2id_valid, if2id_instr, if2id_exc_code} !== {1'b1, 32'h0, EXC_TLB}) begin
            n_fail++;
            $display("FAIL exc_fields: got v=%b i=%h e=%h expected v=1 i=00000000 e=3",
                     if2id_valid, if2id_instr, if2id_exc_code);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_if.mem_req) reqs++;
        end
        n_checks++;
        if (reqs !== 0) begin
            n_fail++; $display("FAIL exc_halted: got %0d request cycles expected 0", reqs);
        end
        jmp_flag = 1'b1; jmp_dest = 32'h200; exc_en = 1'b0;
        @(negedge clk);
        jmp_flag = 1'b0;
        #1;
        n_checks++;
        if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL exc_resume: got req=%b addr=%h expected req=1 addr=00000200",
                     mem_if.mem_req, mem_if.mem_addr);
        end
    endtask

    task automatic test_interrupt();
        logic found = 1'b0;
        mem_lat = 1; exc_en = 1'b0;
        apply_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (if2id_valid && if2id_pc == 32'h1C) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL int_timeout: got no delivery expected pc=0000001c");
        end
        has_int_pending = 1'b1;
        @(negedge clk);
        has_int_pending = 1'b0;
        n_checks++;
        if ({if2id_valid, if2id_instr, if2id_pc, if2id_exc_code} !== {1'b1, 32'h0, 32'h20, EC_INT}) begin
            n_fail++;
            $display("FAIL int_tag: got v=%b i=%h pc=%h e=%h expected v=1 i=0 pc=00000020 e=f",
                     if2id_valid, if2id_instr, if2id_pc, if2id_exc_code);
        end
        @(negedge clk);
        n_checks++;
        if ({if2id_valid, if2id_instr, if2id_pc, if2id_exc_code} !== {1'b1, mem_word(32'h24), 32'h24, EC_NONE}) begin
            n_fail++;
            $display("FAIL int_next: got v=%b i=%h pc=%h e=%h expected pc=00000024",
                     if2id_valid, if2id_instr, if2id_pc, if2id_exc_code);
        end
    endtask

    task automatic test_clear();
        logic found = 1'b0;
        mem_lat = 1; exc_en = 1'b0;
        apply_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (if2id_valid && if2id_pc == 32'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL clear_timeout: got no delivery expected pc=00000008");
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if ({if2id_valid, if2id_instr, if2id_pc, if2id_exc_code} !== {1'b0, 32'h0, 32'h8, EC_NONE}) begin
            n_fail++;
            $display("FAIL clear_bubble: got v=%b i=%h pc=%h e=%h expected v=0 i=0 pc=00000008 e=0",
                     if2id_valid, if2id_instr, if2id_pc, if2id_exc_code);
        end
        @(negedge clk);
        n_checks++;
        if ({if2id_valid, if2id_instr, if2id_pc} !== {1'b1, mem_word(32'hC), 32'hC}) begin
            n_fail++;
            $display("FAIL clear_resume: got v=%b i=%h pc=%h expected pc=0000000c",
                     if2id_valid, if2id_instr, if2id_pc);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000");
        $fatal(1);
    end

    initial begin : main
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_exception();
        test_interrupt();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
